regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
Parametrised multi-register file: the next generation of the 4x32 register file, generalised in data width and depth. Adds per-register pending (busy) tracking for load-use hazard detection, an optional write-to-read bypass, and an optional hardwired-zero register 0. Sits between the datapath decode stage and the ALU operand muxes. Two combinational read ports, one synchronous write port.

Parameters:
DATA_W, 32, data word width in bits
ADDR_W, 2, register address width; NUM_REGS = 2**ADDR_W
ZERO_REG, 0, 1 = register 0 always reads 0, ignores writes, is never busy
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports

Ports:
clk  in  1  system clock, rising-edge active
reset  in  1  asynchronous, active-high reset
readReg1  in  ADDR_W  read port 1 address
readReg2  in  ADDR_W  read port 2 address
readData1  out  DATA_W  read port 1 data
readData2  out  DATA_W  read port 2 data
regWrite  in  1  write enable
writeReg  in  ADDR_W  write address
writeData  in  DATA_W  write data
busySet  in  1  mark busyReg as pending, i.e. a result is outstanding
busyReg  in  ADDR_W  register to mark pending
readBusy1  out  1  register addressed by readReg1 is pending
readBusy2  out  1  register addressed by readReg2 is pending

Behaviour:
- Reset is asynchronous and active-high. When asserted, all registers and all busy bits clear to 0 immediately, regardless of clk. After reset, readData1/2 = 0 and readBusy1/2 = 0.
- Write: on the rising clk edge with regWrite=1, reg[writeReg] <= writeData. Gate with an enable, not by ANDing the clock; every flop runs on clk.
- Read: combinational, zero latency. readDataN = reg[readRegN].
- Bypass (BYPASS=1): if regWrite=1 and writeReg==readRegN, then readDataN = writeData in the same cycle. With BYPASS=0 the new value is visible from the cycle after the edge.
- Busy bits, updated on the rising edge:
  - busySet=1 sets busy[busyReg].
  - regWrite=1 clears busy[writeReg].
  - Same register set and cleared in one cycle: set wins. This represents a new load issued as the old result retires.
  - Set and clear on different registers: both take effect.
- readBusyN = busy[readRegN]. With BYPASS=1, readBusyN is forced to 0 when a write to the same register is presented this cycle and busySet does not target that register in the same cycle.
- ZERO_REG=1:
  - readDataN = 0 and readBusyN = 0 whenever readRegN==0, including under bypass.
  - Writes and busySet to register 0 are discarded.
- Both read ports may address the same register; both return identical data and busy values.
- Reset asserted mid-write: reset dominates and the write is lost. First write accepted at the first rising edge after reset deasserts.
- Addresses are always in range by construction (NUM_REGS = 2**ADDR_W); no out-of-range handling.

Decomposition:
- Shared package rf_pkg:
  - default DATA_W and ADDR_W constants
  - ZERO_REG and BYPASS defaults
  - localparam NUM_REGS
- Sub-module rf_scoreboard:
  - holds the NUM_REGS busy bits with the set/clear priority above
  - provides two combinational lookup outputs
- Top level keeps the data storage array, write decode, bypass muxes and zero-register masking.

Test Plan:
1. Reset: assert reset with no clk edge -> readData1/2 = 0 and readBusy1/2 = 0 immediately. Write 0xDEADBEEF to reg 2, then assert reset -> reg 2 reads 0.
2. Write/read all registers: write reg i = 0x1000+i for i = 0..3, then read pairs (0,3) and (1,2) -> 0x1000/0x1003 and 0x1001/0x1002.
3. Bypass: with reg 1 = 0x5, present a write of 0xA5A5A5A5 to reg 1 and readReg1 = 1 in the same cycle.
   - BYPASS=1 -> readData1 = 0xA5A5A5A5 before the edge.
   - BYPASS=0 -> readData1 = 0x5 before the edge, 0xA5A5A5A5 after.
4. Scoreboard:
   - busySet on reg 3 -> readBusy2 (readReg2 = 3) = 1 next cycle.
   - regWrite to reg 3 with 0x77 -> readBusy2 = 0 in that cycle (BYPASS=1) and 0 after the edge.
   - Simultaneous busySet and regWrite to reg 3 -> busy remains 1.
5. ZERO_REG=1: write 0xFFFFFFFF to reg 0 and busySet reg 0 -> readData1 = 0 and readBusy1 = 0 in the same cycle and after the edge. Reg 1 is unaffected.
6. Width/depth sweep with DATA_W=64, ADDR_W=4: write 0x0123456789ABCDEF to reg 15 and 0x1 to reg 0 (ZERO_REG=0) -> both read back exactly. No aliasing across all 16 addresses.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults for the parametrised register file and its busy scoreboard.
package rf_pkg;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_ADDR_W   = 2;
  localparam int unsigned DEF_ZERO_REG = 0;
  localparam int unsigned DEF_BYPASS   = 1;
  localparam int unsigned NUM_REGS     = 2 ** DEF_ADDR_W;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits for load-use hazard detection; a set beats a clear on the same register.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned ZERO_REG = DEF_ZERO_REG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_set_en,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic              i_clr_en,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic [ADDR_W-1:0] i_rd_addr1,
  input  logic [ADDR_W-1:0] i_rd_addr2,
  output logic              o_busy1,
  output logic              o_busy2
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_d;

  always_comb begin
    w_busy_d = r_busy;
    if (i_clr_en) w_busy_d[i_clr_addr] = 1'b0;
    if (i_set_en) w_busy_d[i_set_addr] = 1'b1;
    // Hardwired zero register can never hold an outstanding result.
    if (ZERO_REG != 0) w_busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_d;
    end
  end

  assign o_busy1 = r_busy[i_rd_addr1];
  assign o_busy2 = r_busy[i_rd_addr2];

endmodule

// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with busy tracking, optional bypass and zero register.
module regfile_param
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned ZERO_REG = DEF_ZERO_REG,
  parameter int unsigned BYPASS   = DEF_BYPASS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic              busySet,
  input  logic [ADDR_W-1:0] busyReg,
  output logic              readBusy1,
  output logic              readBusy2
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_raddr [2];
  logic [DATA_W-1:0] w_rdata [2];
  logic [1:0]        w_sb_busy;
  logic [1:0]        w_rbusy;

  assign w_wr_en = regWrite && !((ZERO_REG != 0) && (writeReg == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[writeReg] <= writeData;
    end
  end

  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .i_set_en  (busySet),
    .i_set_addr(busyReg),
    .i_clr_en  (regWrite),
    .i_clr_addr(writeReg),
    .i_rd_addr1(readReg1),
    .i_rd_addr2(readReg2),
    .o_busy1   (w_sb_busy[0]),
    .o_busy2   (w_sb_busy[1])
  );

  assign w_raddr[0] = readReg1;
  assign w_raddr[1] = readReg2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rdata[p] = r_regs[w_raddr[p]];
      w_rbusy[p] = w_sb_busy[p];
      // Forwarded write retires the pending result unless a new load re-targets it.
      if ((BYPASS != 0) && regWrite && (writeReg == w_raddr[p])) begin
        w_rdata[p] = writeData;
        if (!(busySet && (busyReg == w_raddr[p]))) w_rbusy[p] = 1'b0;
      end
      if ((ZERO_REG != 0) && (w_raddr[p] == '0)) begin
        w_rdata[p] = '0;
        w_rbusy[p] = 1'b0;
      end
    end
  end

  assign readData1 = w_rdata[0];
  assign readData2 = w_rdata[1];
  assign readBusy1 = w_rbusy[0];
  assign readBusy2 = w_rbusy[1];

endmodule

// File: tb/tb_regfile_param.sv
// Directed scoreboard bench: default, zero-reg/no-bypass and 64x16 instances of regfile_param.
module tb_regfile_param;

  localparam int A_RD1 = 0, A_RD2 = 1, A_B1 = 2, A_B2 = 3;
  localparam int B_RD1 = 4, B_RD2 = 5, B_B1 = 6, B_B2 = 7;
  localparam int C_RD1 = 8, C_RD2 = 9, C_B1 = 10, C_B2 = 11;

  typedef struct {
    int          sel;
    logic [63:0] exp;
    string       tag;
  } exp_t;

  logic clk;
  logic reset;

  logic [1:0]  rr1, rr2, wa, ba;
  logic        we, bs;
  logic [31:0] wd;
  logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic        a_b1, a_b2, b_b1, b_b2;

  logic [3:0]  c_rr1, c_rr2, c_wa, c_ba;
  logic        c_we, c_bs;
  logic [63:0] c_wd, c_rd1, c_rd2;
  logic        c_b1, c_b2;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [63:0] exp_c [16];

  regfile_param #(.DATA_W(32), .ADDR_W(2), .ZERO_REG(0), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .readReg1(rr1), .readReg2(rr2),
    .readData1(a_rd1), .readData2(a_rd2), .regWrite(we), .writeReg(wa),
    .writeData(wd), .busySet(bs), .busyReg(ba), .readBusy1(a_b1), .readBusy2(a_b2)
  );

  regfile_param #(.DATA_W(32), .ADDR_W(2), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .readReg1(rr1), .readReg2(rr2),
    .readData1(b_rd1), .readData2(b_rd2), .regWrite(we), .writeReg(wa),
    .writeData(wd), .busySet(bs), .busyReg(ba), .readBusy1(b_b1), .readBusy2(b_b2)
  );

  regfile_param #(.DATA_W(64), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) dut_c (
    .clk(clk), .reset(reset), .readReg1(c_rr1), .readReg2(c_rr2),
    .readData1(c_rd1), .readData2(c_rd2), .regWrite(c_we), .writeReg(c_wa),
    .writeData(c_wd), .busySet(c_bs), .busyReg(c_ba), .readBusy1(c_b1), .readBusy2(c_b2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] observe(int sel);
    case (sel)
      A_RD1:   return {32'h0, a_rd1};
      A_RD2:   return {32'h0, a_rd2};
      A_B1:    return {63'h0, a_b1};
      A_B2:    return {63'h0, a_b2};
      B_RD1:   return {32'h0, b_rd1};
      B_RD2:   return {32'h0, b_rd2};
      B_B1:    return {63'h0, b_b1};
      B_B2:    return {63'h0, b_b2};
      C_RD1:   return c_rd1;
      C_RD2:   return c_rd2;
      C_B1:    return {63'h0, c_b1};
      C_B2:    return {63'h0, c_b2};
      default: return 'x;
    endcase
  endfunction

  task automatic expect_v(input int sel, input logic [63:0] exp, input string tag);
    exp_t e;
    e.sel = sel;
    e.exp = exp;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [63:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      obs = observe(e.sel);
      n_checks++;
      assert (obs === e.exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    rr1 = '0; rr2 = '0; wa = '0; ba = '0; we = 1'b0; bs = 1'b0; wd = '0;
    c_rr1 = '0; c_rr2 = '0; c_wa = '0; c_ba = '0; c_we = 1'b0; c_bs = 1'b0; c_wd = '0;

    // Reset with no clock edge yet
    #2 reset = 1'b1;
    #1;
    expect_v(A_RD1, 64'h0, "rst_a_rd1");
    expect_v(A_RD2, 64'h0, "rst_a_rd2");
    expect_v(A_B1, 64'h0, "rst_a_b1");
    expect_v(A_B2, 64'h0, "rst_a_b2");
    expect_v(B_RD1, 64'h0, "rst_b_rd1");
    expect_v(C_RD1, 64'h0, "rst_c_rd1");
    expect_v(C_B2, 64'h0, "rst_c_b2");
    drain();
    #1 reset = 1'b0;
    tick();

    // Write then reset, including a write held during reset
    wa = 2'd2; wd = 32'hDEADBEEF; we = 1'b1; rr1 = 2'd2;
    tick();
    expect_v(B_RD1, 64'hDEADBEEF, "wr_before_rst");
    drain();
    reset = 1'b1;
    #1;
    expect_v(B_RD1, 64'h0, "async_rst_clears");
    drain();
    tick();
    expect_v(B_RD1, 64'h0, "rst_beats_write");
    drain();
    we = 1'b0;
    #1;
    expect_v(A_RD1, 64'h0, "rst_a_reg2");
    drain();
    reset = 1'b0;
    tick();

    // Write all registers then read pairs
    for (int i = 0; i < 4; i++) begin
      wa = 2'(i); wd = 32'h1000 + 32'(i); we = 1'b1;
      tick();
    end
    we = 1'b0; rr1 = 2'd0; rr2 = 2'd3;
    #1;
    expect_v(A_RD1, 64'h1000, "pair03_a_rd1");
    expect_v(A_RD2, 64'h1003, "pair03_a_rd2");
    expect_v(B_RD1, 64'h0, "pair03_b_zero");
    expect_v(B_RD2, 64'h1003, "pair03_b_rd2");
    drain();
    rr1 = 2'd1; rr2 = 2'd2;
    #1;
    expect_v(A_RD1, 64'h1001, "pair12_a_rd1");
    expect_v(A_RD2, 64'h1002, "pair12_a_rd2");
    expect_v(B_RD1, 64'h1001, "pair12_b_rd1");
    expect_v(B_RD2, 64'h1002, "pair12_b_rd2");
    drain();

    // Bypass
    wa = 2'd1; wd = 32'h5; we = 1'b1;
    tick();
    wd = 32'hA5A5A5A5; rr1 = 2'd1;
    #1;
    expect_v(A_RD1, 64'hA5A5A5A5, "bypass_on_same_cycle");
    expect_v(B_RD1, 64'h5, "bypass_off_same_cycle");
    drain();
    tick();
    we = 1'b0;
    #1;
    expect_v(A_RD1, 64'hA5A5A5A5, "bypass_on_after");
    expect_v(B_RD1, 64'hA5A5A5A5, "bypass_off_after");
    drain();

    // Scoreboard set / clear / priority
    bs = 1'b1; ba = 2'd3; rr2 = 2'd3;
    #1;
    expect_v(A_B2, 64'h0, "busy_not_yet_a");
    expect_v(B_B2, 64'h0, "busy_not_yet_b");
    drain();
    tick();
    bs = 1'b0;
    #1;
    expect_v(A_B2, 64'h1, "busy_set_a");
    expect_v(B_B2, 64'h1, "busy_set_b");
    drain();
    we = 1'b1; wa = 2'd3; wd = 32'h77;
    #1;
    expect_v(A_B2, 64'h0, "busy_clr_bypass_a");
    expect_v(B_B2, 64'h1, "busy_clr_nobypass_b");
    expect_v(A_RD2, 64'h77, "wr77_bypass_a");
    expect_v(B_RD2, 64'h1003, "wr77_old_b");
    drain();
    tick();
    we = 1'b0;
    #1;
    expect_v(A_B2, 64'h0, "busy_clr_after_a");
    expect_v(B_B2, 64'h0, "busy_clr_after_b");
    expect_v(A_RD2, 64'h77, "wr77_after_a");
    expect_v(B_RD2, 64'h77, "wr77_after_b");
    drain();
    bs = 1'b1; ba = 2'd3;
    tick();
    we = 1'b1; wa = 2'd3; wd = 32'h88;
    #1;
    expect_v(A_B2, 64'h1, "set_wins_same_cycle_a");
    expect_v(B_B2, 64'h1, "set_wins_same_cycle_b");
    drain();
    tick();
    bs = 1'b0; we = 1'b0;
    #1;
    expect_v(A_B2, 64'h1, "set_wins_after_a");
    expect_v(B_B2, 64'h1, "set_wins_after_b");
    expect_v(A_RD2, 64'h88, "wr88_a");
    drain();
    bs = 1'b1; ba = 2'd1; we = 1'b1; wa = 2'd3; wd = 32'h99; rr1 = 2'd1;
    tick();
    bs = 1'b0; we = 1'b0;
    #1;
    expect_v(A_B1, 64'h1, "diff_set_a");
    expect_v(A_B2, 64'h0, "diff_clr_a");
    expect_v(B_B1, 64'h1, "diff_set_b");
    expect_v(B_B2, 64'h0, "diff_clr_b");
    drain();

    // Zero register
    we = 1'b1; wa = 2'd0; wd = 32'hFFFFFFFF; bs = 1'b1; ba = 2'd0; rr1 = 2'd0; rr2 = 2'd1;
    #1;
    expect_v(B_RD1, 64'h0, "zero_rd_same_cycle");
    expect_v(B_B1, 64'h0, "zero_busy_same_cycle");
    expect_v(A_RD1, 64'hFFFFFFFF, "nozero_bypass");
    expect_v(A_B1, 64'h0, "nozero_busy_same_cycle");
    expect_v(B_RD2, 64'hA5A5A5A5, "zero_reg1_data");
    expect_v(B_B2, 64'h1, "zero_reg1_busy");
    drain();
    tick();
    we = 1'b0; bs = 1'b0;
    #1;
    expect_v(B_RD1, 64'h0, "zero_rd_after");
    expect_v(B_B1, 64'h0, "zero_busy_after");
    expect_v(A_RD1, 64'hFFFFFFFF, "nozero_rd_after");
    expect_v(A_B1, 64'h1, "nozero_busy_after");
    expect_v(B_RD2, 64'hA5A5A5A5, "zero_reg1_after");
    drain();

    // 64-bit x 16 sweep
    for (int i = 0; i < 16; i++) begin
      if (i == 15) exp_c[i] = 64'h0123456789ABCDEF;
      else if (i == 0) exp_c[i] = 64'h1;
      else exp_c[i] = 64'hC0DE_0000_0000_0000 | (64'(i) << 36) | 64'(i);
      c_wa = 4'(i); c_wd = exp_c[i]; c_we = 1'b1;
      tick();
    end
    c_we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      c_rr1 = 4'(i); c_rr2 = 4'(15 - i);
      #1;
      expect_v(C_RD1, exp_c[i], $sformatf("wide_rd1_r%0d", i));
      expect_v(C_RD2, exp_c[15 - i], $sformatf("wide_rd2_r%0d", 15 - i));
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
